// File: rtl/mdio_master.sv
// IEEE 802.3 clause-22 MDIO management master: preamble + 32-bit frame per command,
// read data captured on MDC rising edges with turnaround error detection.
module mdio_master #(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

  localparam logic [8:0] HALF     = 9'(CLK_DIV);
  localparam logic [8:0] LAST_CNT = 9'(2 * CLK_DIV - 1);
  localparam logic [4:0] PRE_LAST = (PRE_LEN > 0) ? 5'(PRE_LEN - 1) : '0;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] frame_q, frame_d;
  logic        write_q, write_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bit_end;

  assign bit_end   = (cnt_q == LAST_CNT);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mdc       = 1'b0;
    mdio_o    = 1'b1;
    mdio_t    = 1'b1;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          // Read frames carry don't-care TA/DATA here; those bits are released.
          frame_d = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                     2'b10, (cmd_write ? cmd_wdata : 16'h0000)};
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (PRE_LEN == 0) ? FRAME : PRE;
        end
      end

      PRE: begin
        mdc    = (cnt_q >= HALF);
        mdio_t = 1'b0;
        cnt_d  = bit_end ? '0 : cnt_q + 9'd1;
        if (bit_end) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = FRAME;
          end
        end
      end

      FRAME: begin
        mdc    = (cnt_q >= HALF);
        mdio_t = !write_q && (bit_q >= 5'd14);
        mdio_o = mdio_t ? 1'b1 : frame_q[~bit_q];
        // cnt_q == HALF is the cycle in which mdc rises.
        if (!write_q && (cnt_q == HALF)) begin
          if ((bit_q == 5'd15) && mdio_i) err_d = 1'b1;
          if (bit_q >= 5'd16) rdata_d = {rdata_q[14:0], mdio_i};
        end
        cnt_d = bit_end ? '0 : cnt_q + 9'd1;
        if (bit_end) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) state_d = DONE;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
